// File: rtl/gate_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_seq_pkg
// Brief    : Shared types and constants for the Gatter21 gate-model sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package gate_seq_pkg;

    localparam int          c_in_w        = 21;
    localparam int          c_out_w       = 10;
    localparam int          c_sig_w       = 16;
    localparam logic [15:0] c_misr_poly   = 16'h1021;
    // x^21 + x^19 + 1 : feedback taps on bits 20 and 18
    localparam int          c_lfsr_tap_hi = 20;
    localparam int          c_lfsr_tap_lo = 18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

endpackage : gate_seq_pkg
`default_nettype wire

// File: rtl/gate_seq_misr.sv
`default_nettype none
// ============================================================================
// Module   : gate_seq_misr
// Brief    : Shift/XOR signature register with clear and enable.
// Revision : 1.0 - initial release
// ============================================================================
module gate_seq_misr
    import gate_seq_pkg::*;
#(
    parameter int               SIG_W = c_sig_w,
    parameter int               DIN_W = c_out_w,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(c_misr_poly)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIN_W-1:0] i_din,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;

    always_comb begin
        w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(i_din);
    end

    // Clear wins over enable so a new run always starts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= w_sig_next;
        end
    end

    assign o_sig = r_sig;

endmodule : gate_seq_misr
`default_nettype wire

// File: rtl/gate_model_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_model_test_sequencer
// Brief    : LFSR stimulus / MISR response sequencer for one GateModel.
// Revision : 1.0 - initial release
// ============================================================================
module gate_model_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int IN_W          = c_in_w,
    parameter int OUT_W         = c_out_w,
    parameter int SIG_W         = c_sig_w,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [IN_W-1:0]  seed_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [SIG_W-1:0] exp_sig_i,
    input  logic [OUT_W-1:0] resp_i,
    output logic [IN_W-1:0]  stim_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [SIG_W-1:0] sig_o,
    output logic             sig_valid_o,
    output logic             pass_o
);

    localparam int               c_set_w    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_set_w-1:0] c_set_load = c_set_w'(SETTLE_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_next_state;

    logic [IN_W-1:0]    r_lfsr;
    logic [IN_W-1:0]    r_stim;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_pat_cnt;
    logic [SIG_W-1:0]   r_exp;
    logic [c_set_w-1:0] r_settle;
    logic               r_done;
    logic               r_sig_valid;
    logic               r_pass;

    logic               w_accept;
    logic               w_apply;
    logic               w_settle_dec;
    logic               w_capture;
    logic               w_finish;
    logic               w_abort;
    logic [CNT_W-1:0]   w_pat_inc;
    logic               w_last;
    logic [IN_W-1:0]    w_lfsr_next;
    logic [SIG_W-1:0]   w_sig;

    assign w_pat_inc   = r_pat_cnt + CNT_W'(1);
    assign w_last      = (w_pat_inc == r_count);
    assign w_lfsr_next = {r_lfsr[IN_W-2:0], r_lfsr[c_lfsr_tap_hi] ^ r_lfsr[c_lfsr_tap_lo]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort outranks every state transition, including the final DONE step
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_apply      = 1'b0;
        w_settle_dec = 1'b0;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        if ((r_state != ST_IDLE) && abort_i) begin
            w_abort      = 1'b1;
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_accept     = 1'b1;
                        w_next_state = (count_i == '0) ? ST_DONE : ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    w_apply      = 1'b1;
                    w_next_state = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        w_next_state = ST_CAPTURE;
                    end else begin
                        w_settle_dec = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    w_capture    = 1'b1;
                    w_next_state = w_last ? ST_DONE : ST_APPLY;
                end
                ST_DONE: begin
                    w_finish     = 1'b1;
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= '0;
            r_stim      <= '0;
            r_count     <= '0;
            r_pat_cnt   <= '0;
            r_exp       <= '0;
            r_settle    <= '0;
            r_done      <= 1'b0;
            r_sig_valid <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                // All-zero is the LFSR lock-up state, so substitute 1
                r_lfsr      <= (seed_i == '0) ? IN_W'(1) : seed_i;
                r_count     <= count_i;
                r_exp       <= exp_sig_i;
                r_pat_cnt   <= '0;
                r_sig_valid <= 1'b0;
                r_pass      <= 1'b0;
            end
            if (w_apply) begin
                r_stim   <= r_lfsr;
                r_settle <= c_set_load;
            end
            if (w_settle_dec) begin
                r_settle <= r_settle - c_set_w'(1);
            end
            if (w_capture) begin
                r_lfsr    <= w_lfsr_next;
                r_pat_cnt <= w_pat_inc;
            end
            if (w_finish) begin
                r_sig_valid <= 1'b1;
                r_pass      <= (w_sig == r_exp);
            end
            if (w_abort) begin
                r_stim <= '0;
            end
        end
    end

    gate_seq_misr #(
        .SIG_W (SIG_W),
        .DIN_W (OUT_W),
        .POLY  (SIG_W'(c_misr_poly))
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_en  (w_capture),
        .i_din (resp_i),
        .o_sig (w_sig)
    );

    assign stim_o      = r_stim;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign sig_o       = w_sig;
    assign sig_valid_o = r_sig_valid;
    assign pass_o      = r_pass;

endmodule : gate_model_test_sequencer
`default_nettype wire

// File: tb/tb_gate_model_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_model_test_sequencer
// Brief    : Self-checking bench: vector table, random runs vs reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_model_test_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [20:0] seed = '0;
    logic [15:0] count = '0;
    logic [15:0] exp_sig = '0;
    logic [9:0]  resp;
    logic [20:0] stim;
    logic        busy;
    logic        done;
    logic [15:0] sig;
    logic        sig_valid;
    logic        pass;
    bit          mode = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in gate model: loopback, or a folded XOR of the high and low inputs
    assign resp = mode ? (stim[20:11] ^ stim[9:0]) : stim[9:0];

    gate_model_test_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .abort_i     (abort),
        .seed_i      (seed),
        .count_i     (count),
        .exp_sig_i   (exp_sig),
        .resp_i      (resp),
        .stim_o      (stim),
        .busy_o      (busy),
        .done_o      (done),
        .sig_o       (sig),
        .sig_valid_o (sig_valid),
        .pass_o      (pass)
    );

    typedef struct {
        logic [20:0] seed;
        int          n;
        logic [15:0] exp_in;
        bit          m;
        logic [15:0] sig;
        bit          pass;
        logic [20:0] first;
        int          lat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Pattern k (0-based) of a run: the LFSR stepped k times from the seed
    function automatic int ref_stim(input logic [20:0] sd, input int k);
        int l;
        l = (sd == 0) ? 1 : int'(sd);
        for (int i = 0; i < k; i++) begin
            l = ((l * 2) % (1 << 21)) + (((l >> 20) ^ (l >> 18)) & 1);
        end
        return l;
    endfunction

    function automatic logic [15:0] ref_sig(input logic [20:0] sd, input int n, input bit m);
        int s, st, r;
        s = 0;
        for (int i = 0; i < n; i++) begin
            st = ref_stim(sd, i);
            r  = m ? (((st >> 11) ^ st) % 1024) : (st % 1024);
            s  = s * 2;
            if (s >= 65536) s = s ^ 32'h11021;
            s  = s ^ r;
        end
        return 16'(s);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_stim", 32'(stim), 0);
        chk("rst_sig", 32'(sig), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sig_valid", 32'(sig_valid), 0);
        chk("rst_pass", 32'(pass), 0);
        rst = 1'b0;
    endtask

    task automatic run(input logic [20:0] sd, input int n, input logic [15:0] ex, input bit m,
                       output int lat, output logic [20:0] first_stim);
        @(negedge clk);
        mode    = m;
        seed    = sd;
        count   = 16'(n);
        exp_sig = ex;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        lat        = -1;
        first_stim = stim;
        for (int c = 1; c <= n * 4 + 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) first_stim = stim;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_run(input string tag, input int lat, input int exp_lat,
                             input logic [20:0] first, input logic [20:0] exp_first,
                             input logic [15:0] exp_s, input bit exp_p);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_first_stim"}, 32'(first), 32'(exp_first));
        chk({tag, "_sig"}, 32'(sig), 32'(exp_s));
        chk({tag, "_sig_valid"}, 32'(sig_valid), 1);
        chk({tag, "_pass"}, 32'(pass), 32'(exp_p));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        chk({tag, "_hold_valid"}, 32'(sig_valid), 1);
    endtask

    initial begin
        int          lat;
        logic [20:0] first;
        logic [20:0] sd;
        logic [15:0] es;
        int          n;
        bit          m;
        bit          seen;

        tbl[0] = '{21'h000001, 1, 16'h0001, 1'b0, 16'h0001, 1'b1, 21'h000001, 5};
        tbl[1] = '{21'h000001, 2, 16'h0000, 1'b0, 16'h0000, 1'b1, 21'h000001, 9};
        tbl[2] = '{21'h000000, 1, 16'h1234, 1'b0, 16'h0001, 1'b0, 21'h000001, 5};
        tbl[3] = '{21'h000005, 0, 16'h0000, 1'b0, 16'h0000, 1'b1, 21'h000000, 1};
        tbl[4] = '{21'h000001, 3, 16'h0004, 1'b0, 16'h0004, 1'b1, 21'h000001, 13};
        tbl[5] = '{21'h100000, 2, 16'h0001, 1'b0, 16'h0001, 1'b1, 21'h100000, 9};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            do_reset();
            run(tbl[i].seed, tbl[i].n, tbl[i].exp_in, tbl[i].m, lat, first);
            check_run($sformatf("tbl%0d", i), lat, tbl[i].lat, first, tbl[i].first,
                      tbl[i].sig, tbl[i].pass);
        end

        // Randomized back-to-back runs against the reference model
        for (int i = 0; i < 24; i++) begin
            sd = 21'($urandom_range(0, 32'h1FFFFF));
            if (i == 0) sd = '0;
            n  = int'($urandom_range(1, 20));
            m  = 1'($urandom_range(0, 1));
            es = ref_sig(sd, n, m);
            if ($urandom_range(0, 1) == 1) begin
                run(sd, n, es, m, lat, first);
                check_run($sformatf("rnd%0d", i), lat, n * 4 + 1, first,
                          21'(ref_stim(sd, 0)), es, 1'b1);
            end else begin
                run(sd, n, es ^ 16'(1 << $urandom_range(0, 15)), m, lat, first);
                check_run($sformatf("rnd%0d", i), lat, n * 4 + 1, first,
                          21'(ref_stim(sd, 0)), es, 1'b0);
            end
        end

        // Abort in SETTLE of pattern 3, with an ignored start pulse mid-run
        do_reset();
        sd = 21'h0ABCDE;
        @(negedge clk);
        mode = 1'b1; seed = sd; count = 16'd10; exp_sig = '0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; seed = 21'h1; count = 16'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_pre_busy", 32'(busy), 1);
        chk("abort_pre_stim", 32'(stim), 32'(ref_stim(sd, 2)));
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_stim", 32'(stim), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_sig_valid", 32'(sig_valid), 0);
        chk("abort_partial_sig", 32'(sig), 32'(ref_sig(sd, 2, 1'b1)));
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_stays_idle", 32'(seen), 0);

        // Reset together with start, after a completed run left state behind
        run(21'h1, 1, 16'h0001, 1'b0, lat, first);
        check_run("pre_rst", lat, 5, first, 21'h1, 16'h0001, 1'b1);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; seed = 21'h3; count = 16'd4;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        chk("rststart_busy", 32'(busy), 0);
        chk("rststart_stim", 32'(stim), 0);
        chk("rststart_sig", 32'(sig), 0);
        chk("rststart_valid", 32'(sig_valid), 0);
        chk("rststart_pass", 32'(pass), 0);
        @(posedge clk);
        #1;
        chk("rststart_idle", 32'(busy), 0);

        // Reset during CAPTURE of pattern 1
        @(negedge clk);
        mode = 1'b0; seed = 21'h00F0F0; count = 16'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cap_stim", 32'(stim), 32'h00F0F0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstcap_busy", 32'(busy), 0);
        chk("rstcap_stim", 32'(stim), 0);
        chk("rstcap_sig", 32'(sig), 0);
        chk("rstcap_done", 32'(done), 0);
        chk("rstcap_valid", 32'(sig_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstcap_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule : tb_gate_model_test_sequencer
`default_nettype wire
